// File: rtl/slave_regfile.sv
// Slave register file behind a valid/ready port with a programmable wait-state FSM.
// Optional build macro SLAVE_ACC_EN: writes accumulate into the register (mod 8) instead of overwriting.
module slave_regfile #(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [2:0]       addr_in,
    input  logic [2:0]       value_in,
    output logic             ready_out,
    input  logic [2:0]       rd_addr,
    output logic [2:0]       rd_data,
    output logic [CNT_W-1:0] wr_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RDY  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t           state_r;
    state_t           state_next_s;
    logic [3:0]       wait_cnt_r;
    logic [3:0]       wait_cnt_next_s;
    logic             ready_r;
    logic             busy_r;
    logic [2:0]       rd_data_r;
    logic [CNT_W-1:0] wr_count_r;
    logic [2:0]       mem_r [8];
    logic             hs_s;
    logic [2:0]       wr_value_s;

    // ready_r mirrors state_r==ST_RDY, so a handshake is only possible in RDY
    assign hs_s = valid_in && ready_r;

    // Next-state and wait counter; the GAP state swallows the stale valid beat after a handshake
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_in) begin
                    wait_cnt_next_s = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        state_next_s = ST_RDY;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s    = ST_RDY;
                    wait_cnt_next_s = 4'd0;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + 4'd1;
                end
            end
            ST_RDY: begin
                if (hs_s) begin
                    state_next_s = ST_GAP;
                end else begin
                    state_next_s = ST_RDY;
                end
            end
            ST_GAP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s    = ST_IDLE;
                wait_cnt_next_s = 4'd0;
            end
        endcase
    end

    // Value stored on a handshake: overwrite, or accumulate in the SLAVE_ACC_EN build
    always_comb begin
`ifdef SLAVE_ACC_EN
        wr_value_s = mem_r[addr_in] + value_in;
`else
        wr_value_s = value_in;
`endif
    end

    // FSM state, wait counter and flop-decoded ready/busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            ready_r    <= (state_next_s == ST_RDY);
            busy_r     <= (state_next_s != ST_IDLE);
        end
    end

    // Register file and accepted-write counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                mem_r[i] <= 3'd0;
            end
            wr_count_r <= '0;
        end else if (hs_s) begin
            mem_r[addr_in] <= wr_value_s;
            wr_count_r     <= wr_count_r + CNT_W'(1);
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    // Registered read port; a read in the handshake cycle sees the pre-write value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= 3'd0;
        end else begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign ready_out = ready_r;
    assign busy      = busy_r;
    assign rd_data   = rd_data_r;
    assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_slave_regfile.sv
// Directed self-checking bench for slave_regfile (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 second instance).
module tb_slave_regfile;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    logic [2:0] addr_in = 3'd0;
    logic [2:0] value_in = 3'd0;
    logic       ready_out;
    logic [2:0] rd_addr = 3'd0;
    logic [2:0] rd_data;
    logic [7:0] wr_count;
    logic       busy;

    logic       v0_valid = 1'b0;
    logic [2:0] v0_addr = 3'd0;
    logic [2:0] v0_value = 3'd0;
    logic       v0_ready;
    logic [2:0] v0_rd_addr = 3'd0;
    logic [2:0] v0_rd_data;
    logic [7:0] v0_wr_count;
    logic       v0_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slave_regfile #(.WAIT_CYCLES(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .addr_in(addr_in),
        .value_in(value_in), .ready_out(ready_out), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_count(wr_count), .busy(busy)
    );

    slave_regfile #(.WAIT_CYCLES(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .valid_in(v0_valid), .addr_in(v0_addr),
        .value_in(v0_value), .ready_out(v0_ready), .rd_addr(v0_rd_addr),
        .rd_data(v0_rd_data), .wr_count(v0_wr_count), .busy(v0_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", ready_out); end
        checks++;
        if (wr_count !== 8'd0) begin errors++; $display("FAIL reset_wr_count got %0d exp 0", wr_count); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            tick();
            checks++;
            if (rd_data !== 3'd0) begin errors++; $display("FAIL reset_read[%0d] got %0d exp 0", a, rd_data); end
        end
    endtask

    // First write plus the stale-valid beat during GAP
    task automatic test_write_and_stale();
        valid_in = 1'b1;
        addr_in  = 3'd5;
        value_in = 3'd3;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (ready_out !== (i == 3)) begin
                errors++;
                $display("FAIL wait_latency cycle %0d ready got %0b exp %0b", i, ready_out, (i == 3));
            end
        end
        tick();
        value_in = 3'd6;
        checks++;
        if (ready_out !== 1'b0) begin errors++; $display("FAIL gap_ready got %0b exp 0", ready_out); end
        checks++;
        if (wr_count !== 8'd1) begin errors++; $display("FAIL first_wr_count got %0d exp 1", wr_count); end
        tick();
        valid_in = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL stale_idle_busy got %0b exp 0", busy); end
        checks++;
        if (wr_count !== 8'd1) begin errors++; $display("FAIL stale_wr_count got %0d exp 1", wr_count); end
        rd_addr = 3'd5;
        tick();
        checks++;
        if (rd_data !== 3'd3) begin errors++; $display("FAIL stale_read5 got %0d exp 3", rd_data); end
    endtask

    task automatic test_back_to_back();
        int t = 0;
        int nhs = 0;
        int hs_t[2];
        logic hs_now;
        logic [2:0] exp_v;
        valid_in = 1'b1;
        addr_in  = 3'd1;
        value_in = 3'd7;
        while (nhs < 2 && t < 40) begin
            hs_now = valid_in && ready_out;
            tick();
            t++;
            if (hs_now) begin
                hs_t[nhs] = t;
                nhs++;
                value_in = 3'd2;
            end
        end
        valid_in = 1'b0;
        checks++;
        if (nhs != 2) begin
            errors++;
            $display("FAIL b2b_handshakes got %0d exp 2", nhs);
        end else begin
            checks++;
            if (hs_t[1] - hs_t[0] != 5) begin
                errors++;
                $display("FAIL b2b_spacing got %0d exp 5", hs_t[1] - hs_t[0]);
            end
        end
`ifdef SLAVE_ACC_EN
        exp_v = 3'd1;
`else
        exp_v = 3'd2;
`endif
        rd_addr = 3'd1;
        tick();
        checks++;
        if (rd_data !== exp_v) begin errors++; $display("FAIL b2b_read1 got %0d exp %0d", rd_data, exp_v); end
        checks++;
        if (wr_count !== 8'd3) begin errors++; $display("FAIL b2b_wr_count got %0d exp 3", wr_count); end
    endtask

    task automatic test_read_during_write();
        int n = 0;
        logic [2:0] exp_v;
        tick();
        valid_in = 1'b1;
        addr_in  = 3'd5;
        value_in = 3'd4;
        rd_addr  = 3'd5;
        while (!ready_out && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (ready_out !== 1'b1) begin errors++; $display("FAIL rdw_ready_timeout got %0b exp 1", ready_out); end
        tick();
        valid_in = 1'b0;
        checks++;
        if (rd_data !== 3'd3) begin errors++; $display("FAIL rdw_old_value got %0d exp 3", rd_data); end
        tick();
`ifdef SLAVE_ACC_EN
        exp_v = 3'd7;
`else
        exp_v = 3'd4;
`endif
        checks++;
        if (rd_data !== exp_v) begin errors++; $display("FAIL rdw_new_value got %0d exp %0d", rd_data, exp_v); end
        checks++;
        if (wr_count !== 8'd4) begin errors++; $display("FAIL rdw_wr_count got %0d exp 4", wr_count); end
    endtask

    task automatic test_reset_mid_wait();
        tick();
        valid_in = 1'b1;
        addr_in  = 3'd2;
        value_in = 3'd5;
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midwait_busy got %0b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ready_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset busy %0b ready %0b exp 0 0", busy, ready_out);
        end
        checks++;
        if (wr_count !== 8'd0) begin errors++; $display("FAIL async_reset_wr_count got %0d exp 0", wr_count); end
        valid_in = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            tick();
            checks++;
            if (rd_data !== 3'd0) begin errors++; $display("FAIL midwait_read[%0d] got %0d exp 0", a, rd_data); end
        end
        checks++;
        if (wr_count !== 8'd0) begin errors++; $display("FAIL midwait_wr_count got %0d exp 0", wr_count); end
    endtask

    task automatic test_wait0();
        v0_valid = 1'b1;
        v0_addr  = 3'd3;
        v0_value = 3'd6;
        tick();
        checks++;
        if (v0_ready !== 1'b1) begin errors++; $display("FAIL wait0_ready got %0b exp 1", v0_ready); end
        tick();
        v0_valid = 1'b0;
        checks++;
        if (v0_ready !== 1'b0) begin errors++; $display("FAIL wait0_gap_ready got %0b exp 0", v0_ready); end
        v0_rd_addr = 3'd3;
        tick();
        checks++;
        if (v0_rd_data !== 3'd6) begin errors++; $display("FAIL wait0_read3 got %0d exp 6", v0_rd_data); end
        checks++;
        if (v0_wr_count !== 8'd1) begin errors++; $display("FAIL wait0_wr_count got %0d exp 1", v0_wr_count); end
    endtask

    initial begin
        test_reset();
        test_write_and_stale();
        test_back_to_back();
        test_read_during_write();
        test_reset_mid_wait();
        test_wait0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
